// File: rtl/branch_prediction_unit_if.sv
// Fetch/resolve/statistics bundle between the pipeline and branch_prediction_unit.
// master = pipeline side, slave = predictor side.
interface branch_prediction_unit_if #(
  parameter int ADDR_W   = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 16
);
  logic [ADDR_W-1:0]   Fetch_PC;
  logic                Pred_Taken;
  logic [IDX_BITS-1:0] Pred_Index;
  logic                Ex_Valid;
  logic [IDX_BITS-1:0] Ex_Index;
  logic                Ex_Pred_Taken;
  logic [2:0]          Funct_3;
  logic                Z_Flag;
  logic                S_Flag;
  logic                V_Flag;
  logic                C_Flag;
  logic                Branch_Taken;
  logic                Mispredict;
  logic                Clear_Stats;
  logic [CNT_W-1:0]    Branch_Count;
  logic [CNT_W-1:0]    Mispredict_Count;

  modport master (
    output Fetch_PC, Ex_Valid, Ex_Index, Ex_Pred_Taken, Funct_3,
           Z_Flag, S_Flag, V_Flag, C_Flag, Clear_Stats,
    input  Pred_Taken, Pred_Index, Branch_Taken, Mispredict,
           Branch_Count, Mispredict_Count
  );

  modport slave (
    input  Fetch_PC, Ex_Valid, Ex_Index, Ex_Pred_Taken, Funct_3,
           Z_Flag, S_Flag, V_Flag, C_Flag, Clear_Stats,
    output Pred_Taken, Pred_Index, Branch_Taken, Mispredict,
           Branch_Count, Mispredict_Count
  );
endinterface

// File: rtl/branch_prediction_unit.sv
// 2-bit saturating-counter branch predictor with B-type resolve and mispredict stats.
// Define BPU_GSHARE_EN to XOR a global history register into the fetch index.

module bpu_ctr_entry #(
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] state
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_STATE;
    end else if (upd) begin
      if (taken) begin
        if (state != 2'b11) state <= state + 2'd1;
      end else begin
        if (state != 2'b00) state <= state - 2'd1;
      end
    end
  end
endmodule

module branch_prediction_unit #(
  parameter int         ADDR_W     = 32,
  parameter int         IDX_BITS   = 6,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_W      = 16
) (
  input logic                     Clk,
  input logic                     Rst_N,
  branch_prediction_unit_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0][1:0] tbl;
  logic [ENTRIES-1:0]      upd_vec;
  logic [IDX_BITS-1:0]     pc_idx;
  logic [IDX_BITS-1:0]     fetch_idx;
  logic                    cond;
  logic                    taken;
  logic                    mispred;
  logic [CNT_W-1:0]        br_cnt;
  logic [CNT_W-1:0]        mp_cnt;
  logic                    unused_pc_bits;

  assign pc_idx         = bus.Fetch_PC[IDX_BITS+1:2];
  assign unused_pc_bits = ^{bus.Fetch_PC[ADDR_W-1:IDX_BITS+2], bus.Fetch_PC[1:0]};

  // Funct_3 encodings 010/011 are not branches and resolve not-taken.
  always_comb begin
    cond = 1'b0;
    case (bus.Funct_3)
      3'b000:  cond = bus.Z_Flag;
      3'b001:  cond = ~bus.Z_Flag;
      3'b100:  cond = bus.S_Flag ^ bus.V_Flag;
      3'b101:  cond = ~(bus.S_Flag ^ bus.V_Flag);
      3'b110:  cond = ~bus.C_Flag;
      3'b111:  cond = bus.C_Flag;
      default: cond = 1'b0;
    endcase
  end

  assign taken   = bus.Ex_Valid & cond;
  assign mispred = bus.Ex_Valid & (taken != bus.Ex_Pred_Taken);

`ifdef BPU_GSHARE_EN
  logic [IDX_BITS-1:0] ghr;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N)            ghr <= '0;
    else if (bus.Ex_Valid) ghr <= {ghr[IDX_BITS-2:0], taken};
  end

  // Fetch sees the pre-shift history when a resolve lands in the same cycle.
  assign fetch_idx = pc_idx ^ ghr;
`else
  assign fetch_idx = pc_idx;
`endif

  genvar i;
  generate
    for (i = 0; i < ENTRIES; i++) begin : g_entry
      assign upd_vec[i] = bus.Ex_Valid && (bus.Ex_Index == IDX_BITS'(i));
      bpu_ctr_entry #(.INIT_STATE(INIT_STATE)) u_ctr (
        .clk   (Clk),
        .rst_n (Rst_N),
        .upd   (upd_vec[i]),
        .taken (taken),
        .state (tbl[i])
      );
    end
  endgenerate

  // No write-to-read bypass: a colliding fetch sees the old counter.
  assign bus.Pred_Taken = tbl[fetch_idx][1];
  assign bus.Pred_Index = fetch_idx;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (bus.Clear_Stats) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (bus.Ex_Valid && (br_cnt != '1)) br_cnt <= br_cnt + CNT_W'(1);
      if (mispred && (mp_cnt != '1))      mp_cnt <= mp_cnt + CNT_W'(1);
    end
  end

  assign bus.Branch_Taken     = taken;
  assign bus.Mispredict       = mispred;
  assign bus.Branch_Count     = br_cnt;
  assign bus.Mispredict_Count = mp_cnt;
endmodule

// File: tb/tb_branch_prediction_unit.sv
// Table-driven + scoreboard bench for branch_prediction_unit (CNT_W=4 to reach saturation).
module tb_branch_prediction_unit;
  localparam int         ADDR_W   = 32;
  localparam int         IDX_BITS = 6;
  localparam int         CNT_W    = 4;
  localparam logic [1:0] INIT     = 2'b01;
  localparam int         CMAX     = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Rst_N = 1'b0;
  always #5 Clk = ~Clk;

  branch_prediction_unit_if #(.ADDR_W(ADDR_W), .IDX_BITS(IDX_BITS), .CNT_W(CNT_W)) bif ();

  branch_prediction_unit #(
    .ADDR_W(ADDR_W), .IDX_BITS(IDX_BITS), .INIT_STATE(INIT), .CNT_W(CNT_W)
  ) dut (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .bus   (bif)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model
  logic [1:0] mtbl [64];
  logic [5:0] mghr;
  int         mbc, mmc;

  typedef struct {
    logic [5:0] pidx;
    logic       pt;
    logic       bt;
    logic       mp;
  } exp_t;
  exp_t sbq[$];

  function automatic logic mcond(input logic [2:0] f, input logic [3:0] fl);
    logic z, s, v, c;
    z = fl[3]; s = fl[2]; v = fl[1]; c = fl[0];
    case (f)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return s != v;
      3'd5:    return s == v;
      3'd6:    return !c;
      3'd7:    return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] midx(input logic [31:0] pc);
`ifdef BPU_GSHARE_EN
    return pc[7:2] ^ mghr;
`else
    return pc[7:2];
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 64; k++) mtbl[k] = INIT;
    mghr = '0; mbc = 0; mmc = 0;
  endtask

  // Called at a negedge: drive, score combinational outputs, clock once,
  // then score the registered counts at the following negedge.
  task automatic step(input logic [31:0] pc, input logic ev, input logic [5:0] idx,
                      input logic ept, input logic [2:0] f3, input logic [3:0] fl,
                      input logic clr);
    exp_t e, got;
    bif.Fetch_PC = pc; bif.Ex_Valid = ev; bif.Ex_Index = idx; bif.Ex_Pred_Taken = ept;
    bif.Funct_3 = f3; {bif.Z_Flag, bif.S_Flag, bif.V_Flag, bif.C_Flag} = fl;
    bif.Clear_Stats = clr;
    e.pidx = midx(pc);
    e.pt   = mtbl[e.pidx][1];
    e.bt   = ev & mcond(f3, fl);
    e.mp   = ev & (e.bt != ept);
    sbq.push_back(e);
    #2;
    got = sbq.pop_front();
    chk("pred_index", bif.Pred_Index, got.pidx);
    chk("pred_taken", bif.Pred_Taken, got.pt);
    chk("branch_taken", bif.Branch_Taken, got.bt);
    chk("mispredict", bif.Mispredict, got.mp);
    @(posedge Clk);
    if (ev) begin
      if (got.bt) mtbl[idx] = (mtbl[idx] == 2'b11) ? 2'b11 : mtbl[idx] + 2'd1;
      else        mtbl[idx] = (mtbl[idx] == 2'b00) ? 2'b00 : mtbl[idx] - 2'd1;
      mghr = {mghr[4:0], got.bt};
    end
    if (clr) begin
      mbc = 0; mmc = 0;
    end else begin
      if (ev && mbc < CMAX) mbc++;
      if (got.mp && mmc < CMAX) mmc++;
    end
    @(negedge Clk);
    chk("branch_count", bif.Branch_Count, mbc);
    chk("mispredict_count", bif.Mispredict_Count, mmc);
  endtask

  task automatic check_pred(input string name);
    #1;
    chk(name, bif.Pred_Taken, mtbl[midx(bif.Fetch_PC)][1]);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    bif.Ex_Valid = 1'b0; bif.Clear_Stats = 1'b0;
    Rst_N = 1'b0;
    model_reset();
    #2;
    Rst_N = 1'b1;
    @(negedge Clk);
  endtask

  typedef struct {
    logic [2:0] f3;
    logic [3:0] fl;   // {Z,S,V,C}
    logic       ev;
    logic       ept;
    logic       exp_bt;
  } vec_t;
  vec_t vecs[$];

  initial begin
    vecs = '{
      '{3'b000, 4'b1000, 1'b1, 1'b0, 1'b1},
      '{3'b000, 4'b0111, 1'b1, 1'b0, 1'b0},
      '{3'b001, 4'b0000, 1'b1, 1'b0, 1'b1},
      '{3'b001, 4'b1000, 1'b1, 1'b1, 1'b0},
      '{3'b100, 4'b0100, 1'b1, 1'b0, 1'b1},
      '{3'b100, 4'b0110, 1'b1, 1'b0, 1'b0},
      '{3'b100, 4'b0010, 1'b1, 1'b1, 1'b1},
      '{3'b101, 4'b0110, 1'b1, 1'b0, 1'b1},
      '{3'b101, 4'b0010, 1'b1, 1'b0, 1'b0},
      '{3'b110, 4'b1110, 1'b1, 1'b0, 1'b1},
      '{3'b110, 4'b0001, 1'b1, 1'b0, 1'b0},
      '{3'b111, 4'b0001, 1'b1, 1'b0, 1'b1},
      '{3'b111, 4'b1110, 1'b1, 1'b1, 1'b0},
      '{3'b011, 4'b1111, 1'b1, 1'b0, 1'b0},
      '{3'b000, 4'b1000, 1'b0, 1'b1, 1'b0},
      '{3'b111, 4'b0001, 1'b0, 1'b0, 1'b0}
    };

    bif.Fetch_PC = '0; bif.Ex_Valid = 1'b0; bif.Ex_Index = '0; bif.Ex_Pred_Taken = 1'b0;
    bif.Funct_3 = '0; bif.Z_Flag = 1'b0; bif.S_Flag = 1'b0; bif.V_Flag = 1'b0;
    bif.C_Flag = 1'b0; bif.Clear_Stats = 1'b0;
    model_reset();

    // Reset state across every table entry
    for (int a = 0; a < 64; a++) begin
      bif.Fetch_PC = 32'(a * 4);
      #1;
      chk("rst_pred_taken", bif.Pred_Taken, 1'b0);
      chk("rst_pred_index", bif.Pred_Index, a);
    end
    chk("rst_branch_count", bif.Branch_Count, 0);
    chk("rst_mispredict_count", bif.Mispredict_Count, 0);
    @(negedge Clk);
    Rst_N = 1'b1;
    @(negedge Clk);

    // Condition table
    foreach (vecs[n]) begin
      step(32'h100, vecs[n].ev, 6'd20, vecs[n].ept, vecs[n].f3, vecs[n].fl, 1'b0);
      chk("cond_table_bt", bif.Branch_Taken, vecs[n].exp_bt);
    end
    for (int fl = 0; fl < 16; fl++) begin
      step(32'h100, 1'b1, 6'd21, 1'b0, 3'b010, 4'(fl), 1'b0);
      chk("funct3_010_bt", bif.Branch_Taken, 1'b0);
    end

    // Collision: fetch of PC 0x14 while entry 5 moves 01->10
    do_reset();
    step(32'h14, 1'b1, 6'd5, 1'b0, 3'b000, 4'b1000, 1'b0);
    bif.Ex_Valid = 1'b0;
    check_pred("collision_next");
`ifndef BPU_GSHARE_EN
    chk("collision_next_const", bif.Pred_Taken, 1'b1);
`endif

    // Saturation on entry 5
    do_reset();
    step(32'h14, 1'b1, 6'd5, 1'b0, 3'b111, 4'b0001, 1'b0);
    chk("sat_first_mispredict_cnt", bif.Mispredict_Count, 1);
    bif.Ex_Valid = 1'b0;
    check_pred("sat_flip");
    for (int k = 0; k < 4; k++) step(32'h14, 1'b1, 6'd5, 1'b1, 3'b111, 4'b0001, 1'b0);
    step(32'h14, 1'b1, 6'd5, 1'b1, 3'b111, 4'b0000, 1'b0);
    bif.Ex_Valid = 1'b0;
    check_pred("sat_after_nt");
`ifndef BPU_GSHARE_EN
    chk("sat_after_nt_const", bif.Pred_Taken, 1'b1);
`endif

    // Statistics saturation and clear priority
    step(32'h0, 1'b0, 6'd0, 1'b0, 3'b000, 4'b0000, 1'b1);
    for (int k = 0; k < 20; k++) step(32'h0, 1'b1, 6'd9, 1'b0, 3'b000, 4'b1000, 1'b0);
    chk("stat_bc_sat", bif.Branch_Count, CMAX);
    chk("stat_mc_sat", bif.Mispredict_Count, CMAX);
    step(32'h0, 1'b1, 6'd9, 1'b0, 3'b000, 4'b1000, 1'b1);
    chk("stat_clear_bc", bif.Branch_Count, 0);
    chk("stat_clear_mc", bif.Mispredict_Count, 0);

    // Asynchronous reset in the middle of an update
    do_reset();
    step(32'h14, 1'b1, 6'd5, 1'b0, 3'b000, 4'b1000, 1'b0);
    bif.Fetch_PC = 32'h14; bif.Ex_Valid = 1'b1; bif.Ex_Index = 6'd5;
    @(posedge Clk);
    #2;
    Rst_N = 1'b0;
    #1;
    model_reset();
    chk("async_rst_bc", bif.Branch_Count, 0);
    chk("async_rst_mc", bif.Mispredict_Count, 0);
    chk("async_rst_pred", bif.Pred_Taken, 1'b0);
    chk("async_rst_idx", bif.Pred_Index, 6'd5);
    @(negedge Clk);
    bif.Ex_Valid = 1'b0;
    Rst_N = 1'b1;
    @(negedge Clk);

`ifdef BPU_GSHARE_EN
    // History: taken, taken, not-taken -> low bits 110
    do_reset();
    step(32'h40, 1'b1, 6'd0, 1'b0, 3'b111, 4'b0001, 1'b0);
    step(32'h40, 1'b1, 6'd0, 1'b0, 3'b111, 4'b0001, 1'b0);
    step(32'h40, 1'b1, 6'd0, 1'b0, 3'b111, 4'b0000, 1'b0);
    bif.Ex_Valid = 1'b0; bif.Fetch_PC = 32'h0;
    #1;
    chk("gshare_index", bif.Pred_Index, 6'b000110);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
